// File: rtl/ppr_pkg.sv
// Shared types and timing defaults for the post-package-repair command sequencer.
package ppr_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        SOFT = 2'b01,
        HARD = 2'b10,
        RSVD = 2'b11
    } ppr_type_e;

    typedef enum logic [2:0] {
        NOP       = 3'd0,
        MRS_ENTER = 3'd1,
        ACT       = 3'd2,
        PRE       = 3'd3,
        MRS_EXIT  = 3'd4
    } ppr_cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        PGM_ACT = 3'd2,
        PRECH   = 3'd3,
        EXIT    = 3'd4,
        DONE    = 3'd5
    } ppr_state_e;

    localparam int TIMER_W    = 16;
    localparam int T_MOD_DEF  = 8;
    localparam int T_RP_DEF   = 4;
    localparam int T_SPPR_DEF = 16;
    localparam int T_HPPR_DEF = 64;

    // Only soft and hard entries produce a command sequence; the rest are skipped.
    function automatic logic is_repair(input logic [1:0] entry_type);
        return (entry_type == SOFT) || (entry_type == HARD);
    endfunction

endpackage

// File: rtl/ppr_wait_timer.sv
// Loadable down-counter; expired is high in the last cycle of a W-cycle wait.
module ppr_wait_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == W'(1));

endmodule

// File: rtl/ppr_sequencer.sv
// Expands buffered PPR fail entries into MRS/ACT/PRE/MRS command sequences.
// Optional per-pass repaired/skipped counters are enabled with PPR_SEQ_STATS_EN.
module ppr_sequencer
    import ppr_pkg::*;
#(
    parameter int N_CH      = 32,
    parameter int CH_WIDTH  = $clog2(N_CH),
    parameter int ADDR_SIZE = 24,
    parameter int T_MOD     = T_MOD_DEF,
    parameter int T_RP      = T_RP_DEF,
    parameter int T_SPPR    = T_SPPR_DEF,
    parameter int T_HPPR    = T_HPPR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_valid_i,
    output logic                 entry_ready_o,
    input  logic [1:0]           entry_type_i,
    input  logic [ADDR_SIZE-1:0] entry_addr_i,
    input  logic [CH_WIDTH-1:0]  entry_ch_i,
    input  logic                 entry_last_i,
    output logic                 cmd_valid_o,
    output logic [2:0]           cmd_o,
    output logic                 cmd_hppr_o,
    output logic [CH_WIDTH-1:0]  cmd_ch_o,
    output logic [ADDR_SIZE-1:0] cmd_addr_o,
    output logic                 entry_done_o,
    output logic                 pass_done_o,
    output logic                 busy_o
`ifdef PPR_SEQ_STATS_EN
    ,
    output logic [15:0]          repaired_cnt_o,
    output logic [15:0]          skipped_cnt_o
`endif
);

    ppr_state_e           state_reg;
    ppr_cmd_e             cmd_reg;
    logic                 cmd_valid_reg;
    logic                 ready_reg;
    logic                 busy_reg;
    logic                 hppr_reg;
    logic                 last_reg;
    logic [CH_WIDTH-1:0]  ch_reg;
    logic [ADDR_SIZE-1:0] addr_reg;
    logic                 entry_done_reg;
    logic                 pass_done_reg;

    logic                 accept;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_expired;

    assign accept = entry_valid_i & ready_reg;

    // The timer is reloaded on the same edge that issues the next command.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_reg)
            IDLE: begin
                if (accept && is_repair(entry_type_i)) begin
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(T_MOD);
                end
            end
            ENTER: begin
                if (timer_expired) begin
                    timer_load = 1'b1;
                    timer_val  = hppr_reg ? TIMER_W'(T_HPPR) : TIMER_W'(T_SPPR);
                end
            end
            PGM_ACT: begin
                if (timer_expired) begin
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(T_RP);
                end
            end
            PRECH: begin
                if (timer_expired) begin
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(T_MOD);
                end
            end
            default: begin
                timer_load = 1'b0;
                timer_val  = '0;
            end
        endcase
    end

    ppr_wait_timer #(
        .W (TIMER_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cmd_reg        <= NOP;
            cmd_valid_reg  <= 1'b0;
            ready_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            hppr_reg       <= 1'b0;
            last_reg       <= 1'b0;
            ch_reg         <= '0;
            addr_reg       <= '0;
            entry_done_reg <= 1'b0;
            pass_done_reg  <= 1'b0;
        end else begin
            cmd_valid_reg  <= 1'b0;
            cmd_reg        <= NOP;
            entry_done_reg <= 1'b0;
            pass_done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        ch_reg    <= entry_ch_i;
                        addr_reg  <= entry_addr_i;
                        last_reg  <= entry_last_i;
                        if (is_repair(entry_type_i)) begin
                            hppr_reg      <= (entry_type_i == HARD);
                            state_reg     <= ENTER;
                            cmd_valid_reg <= 1'b1;
                            cmd_reg       <= MRS_ENTER;
                        end else begin
                            // Skipped entry: report completion without touching the bus.
                            hppr_reg       <= 1'b0;
                            state_reg      <= DONE;
                            entry_done_reg <= 1'b1;
                            pass_done_reg  <= entry_last_i;
                        end
                    end
                end
                ENTER: begin
                    if (timer_expired) begin
                        state_reg     <= PGM_ACT;
                        cmd_valid_reg <= 1'b1;
                        cmd_reg       <= ACT;
                    end
                end
                PGM_ACT: begin
                    if (timer_expired) begin
                        state_reg     <= PRECH;
                        cmd_valid_reg <= 1'b1;
                        cmd_reg       <= PRE;
                    end
                end
                PRECH: begin
                    if (timer_expired) begin
                        state_reg     <= EXIT;
                        cmd_valid_reg <= 1'b1;
                        cmd_reg       <= MRS_EXIT;
                    end
                end
                EXIT: begin
                    if (timer_expired) begin
                        state_reg      <= DONE;
                        entry_done_reg <= 1'b1;
                        pass_done_reg  <= last_reg;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    hppr_reg  <= 1'b0;
                    last_reg  <= 1'b0;
                    ch_reg    <= '0;
                    addr_reg  <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign entry_ready_o = ready_reg;
    assign cmd_valid_o   = cmd_valid_reg;
    assign cmd_o         = cmd_reg;
    assign cmd_hppr_o    = hppr_reg;
    assign cmd_ch_o      = ch_reg;
    assign cmd_addr_o    = addr_reg;
    assign entry_done_o  = entry_done_reg;
    assign pass_done_o   = pass_done_reg;
    assign busy_o        = busy_reg;

`ifdef PPR_SEQ_STATS_EN
    logic [15:0] repaired_cnt_reg;
    logic [15:0] skipped_cnt_reg;
    logic        done_skip;
    logic        done_repair;

    // Count on entry into DONE so the value including the last entry is visible there.
    assign done_skip   = (state_reg == IDLE) && accept && !is_repair(entry_type_i);
    assign done_repair = (state_reg == EXIT) && timer_expired;

    always_ff @(posedge clk) begin
        if (!rst_n || pass_done_reg) begin
            repaired_cnt_reg <= '0;
            skipped_cnt_reg  <= '0;
        end else begin
            if (done_repair && (repaired_cnt_reg != 16'hFFFF)) begin
                repaired_cnt_reg <= repaired_cnt_reg + 16'd1;
            end
            if (done_skip && (skipped_cnt_reg != 16'hFFFF)) begin
                skipped_cnt_reg <= skipped_cnt_reg + 16'd1;
            end
        end
    end

    assign repaired_cnt_o = repaired_cnt_reg;
    assign skipped_cnt_o  = skipped_cnt_reg;
`endif

endmodule

// File: tb/tb_ppr_sequencer.sv
// Directed bench for ppr_sequencer: default timing on dut, shortened timing on dut_fast.
module tb_ppr_sequencer;
    import ppr_pkg::*;

    localparam int CW = 5;
    localparam int AW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          entry_valid_i = 1'b0;
    logic          entry_ready_o;
    logic [1:0]    entry_type_i = 2'b00;
    logic [AW-1:0] entry_addr_i = '0;
    logic [CW-1:0] entry_ch_i = '0;
    logic          entry_last_i = 1'b0;
    logic          cmd_valid_o;
    logic [2:0]    cmd_o;
    logic          cmd_hppr_o;
    logic [CW-1:0] cmd_ch_o;
    logic [AW-1:0] cmd_addr_o;
    logic          entry_done_o;
    logic          pass_done_o;
    logic          busy_o;

    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [1:0]    b_type = 2'b00;
    logic [AW-1:0] b_addr = '0;
    logic [CW-1:0] b_ch = '0;
    logic          b_last = 1'b0;
    logic          b_cmd_valid;
    logic [2:0]    b_cmd;
    logic          b_hppr;
    logic [CW-1:0] b_cmd_ch;
    logic [AW-1:0] b_cmd_addr;
    logic          b_entry_done;
    logic          b_pass_done;
    logic          b_busy;

`ifdef PPR_SEQ_STATS_EN
    logic [15:0] repaired_cnt_o, skipped_cnt_o, b_rep_cnt, b_skip_cnt;
    logic [15:0] snap_rep = '0, snap_skip = '0;
    always @(negedge clk) begin
        if (entry_done_o) begin
            snap_rep  = repaired_cnt_o;
            snap_skip = skipped_cnt_o;
        end
    end
`endif

    ppr_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .entry_valid_i(entry_valid_i), .entry_ready_o(entry_ready_o),
        .entry_type_i(entry_type_i), .entry_addr_i(entry_addr_i),
        .entry_ch_i(entry_ch_i), .entry_last_i(entry_last_i),
        .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .cmd_hppr_o(cmd_hppr_o),
        .cmd_ch_o(cmd_ch_o), .cmd_addr_o(cmd_addr_o),
        .entry_done_o(entry_done_o), .pass_done_o(pass_done_o), .busy_o(busy_o)
`ifdef PPR_SEQ_STATS_EN
        , .repaired_cnt_o(repaired_cnt_o), .skipped_cnt_o(skipped_cnt_o)
`endif
    );

    ppr_sequencer #(.T_MOD(1), .T_RP(1), .T_SPPR(3), .T_HPPR(5)) dut_fast (
        .clk(clk), .rst_n(rst_n),
        .entry_valid_i(b_valid), .entry_ready_o(b_ready),
        .entry_type_i(b_type), .entry_addr_i(b_addr),
        .entry_ch_i(b_ch), .entry_last_i(b_last),
        .cmd_valid_o(b_cmd_valid), .cmd_o(b_cmd), .cmd_hppr_o(b_hppr),
        .cmd_ch_o(b_cmd_ch), .cmd_addr_o(b_cmd_addr),
        .entry_done_o(b_entry_done), .pass_done_o(b_pass_done), .busy_o(b_busy)
`ifdef PPR_SEQ_STATS_EN
        , .repaired_cnt_o(b_rep_cnt), .skipped_cnt_o(b_skip_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Present one entry in the current (IDLE) cycle and check every cycle until back in IDLE.
    task automatic run_seq(input logic [1:0] typ, input logic [AW-1:0] addr,
                           input logic [CW-1:0] ch, input logic last);
        logic rep, hard, evld;
        logic [2:0] ecmd;
        int tact, e_act, e_pre, e_ext, e_done;
        rep   = (typ == 2'b01) || (typ == 2'b10);
        hard  = (typ == 2'b10);
        tact  = hard ? 64 : 16;
        e_act = 1 + 8;
        e_pre = e_act + tact;
        e_ext = e_pre + 4;
        e_done = rep ? e_ext + 8 : 1;
        chk("ready_at_accept", 0, {31'b0, entry_ready_o}, 32'd1);
        entry_valid_i = 1'b1;
        entry_type_i  = typ;
        entry_addr_i  = addr;
        entry_ch_i    = ch;
        entry_last_i  = last;
        @(negedge clk);
        entry_valid_i = 1'b0;
        entry_type_i  = 2'b10;
        entry_addr_i  = AW'($urandom);
        entry_ch_i    = CW'($urandom);
        entry_last_i  = 1'b1;
        for (int k = 1; k <= e_done + 1; k++) begin
            evld = 1'b0;
            ecmd = 3'd0;
            if (rep) begin
                if (k == 1)     begin evld = 1'b1; ecmd = 3'd1; end
                if (k == e_act) begin evld = 1'b1; ecmd = 3'd2; end
                if (k == e_pre) begin evld = 1'b1; ecmd = 3'd3; end
                if (k == e_ext) begin evld = 1'b1; ecmd = 3'd4; end
            end
            chk("cmd_valid", k, {31'b0, cmd_valid_o}, {31'b0, evld});
            chk("cmd", k, {29'b0, cmd_o}, {29'b0, ecmd});
            chk("entry_done", k, {31'b0, entry_done_o}, {31'b0, k == e_done});
            chk("pass_done", k, {31'b0, pass_done_o}, {31'b0, (k == e_done) && last});
            chk("busy", k, {31'b0, busy_o}, {31'b0, k <= e_done});
            chk("entry_ready", k, {31'b0, entry_ready_o}, {31'b0, k > e_done});
            chk("cmd_ch", k, {27'b0, cmd_ch_o}, (k <= e_done) ? {27'b0, ch} : 32'd0);
            chk("cmd_addr", k, {8'b0, cmd_addr_o}, (k <= e_done) ? {8'b0, addr} : 32'd0);
            chk("cmd_hppr", k, {31'b0, cmd_hppr_o}, {31'b0, hard && (k <= e_done)});
            if (k <= e_done) @(negedge clk);
        end
    endtask

    initial begin
        int acc[3];
        logic [AW-1:0] act_addr[3];
        logic [AW-1:0] qaddr[3];
        int idx, act_n, ready_bad, stray, at[8], done_at, tact;
        logic took;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", 0, {31'b0, entry_ready_o}, 32'd1);
        chk("rst_busy", 0, {31'b0, busy_o}, 32'd0);
        chk("rst_cmd_valid", 0, {31'b0, cmd_valid_o}, 32'd0);
        chk("rst_done", 0, {30'b0, entry_done_o, pass_done_o}, 32'd0);
        chk("rst_ch_addr", 0, {3'b0, cmd_ch_o, cmd_addr_o}, 32'd0);

        run_seq(2'b01, 24'h00ABCD, 5'd5, 1'b1);
`ifdef PPR_SEQ_STATS_EN
        chk("soft_rep_cnt_in_done", 37, {16'b0, snap_rep}, 32'd1);
        chk("soft_rep_cnt_cleared", 38, {16'b0, repaired_cnt_o}, 32'd0);
`endif
        run_seq(2'b10, 24'hFFFFFF, 5'd31, 1'b1);
        run_seq(2'b00, 24'h000123, 5'd2, 1'b0);
        run_seq(2'b11, 24'h000456, 5'd3, 1'b1);
`ifdef PPR_SEQ_STATS_EN
        chk("skip_cnt_before_clear", 3, {16'b0, snap_skip}, 32'd2);
        chk("skip_cnt_cleared", 4, {16'b0, skipped_cnt_o}, 32'd0);
`endif

        // Three soft entries with entry_valid_i held high.
        qaddr[0] = 24'h111111; qaddr[1] = 24'h222222; qaddr[2] = 24'h333333;
        acc = '{-1, -1, -1};
        act_addr = '{24'h0, 24'h0, 24'h0};
        idx = 0; act_n = 0; ready_bad = 0;
        entry_valid_i = 1'b1; entry_type_i = 2'b01; entry_ch_i = 5'd7;
        entry_addr_i = qaddr[0]; entry_last_i = 1'b0;
        for (int c = 0; c < 125; c++) begin
            took = 1'b0;
            if (cmd_valid_o && cmd_o == 3'd2) begin
                if (act_n < 3) act_addr[act_n] = cmd_addr_o;
                act_n++;
            end
            if (c >= 1 && c <= 37 && entry_ready_o) ready_bad++;
            if (entry_ready_o && entry_valid_i && idx < 3) begin
                acc[idx] = c;
                idx++;
                took = 1'b1;
            end
            @(negedge clk);
            if (took) begin
                if (idx < 3) begin
                    entry_addr_i = qaddr[idx];
                    entry_last_i = (idx == 2);
                end else begin
                    entry_valid_i = 1'b0;
                end
            end
        end
        entry_valid_i = 1'b0;
        chk("queue_accepts", 0, idx, 3);
        chk("queue_acc0", 0, acc[0], 0);
        chk("queue_acc1", 0, acc[1], 38);
        chk("queue_acc2", 0, acc[2], 76);
        chk("queue_ready_low", 0, ready_bad, 0);
        chk("queue_act_count", 0, act_n, 3);
        chk("queue_act_addr0", 0, {8'b0, act_addr[0]}, {8'b0, qaddr[0]});
        chk("queue_act_addr1", 0, {8'b0, act_addr[1]}, {8'b0, qaddr[1]});
        chk("queue_act_addr2", 0, {8'b0, act_addr[2]}, {8'b0, qaddr[2]});

        // Reset in the middle of a hard sequence.
        chk("rst_test_idle", 0, {31'b0, entry_ready_o}, 32'd1);
        entry_valid_i = 1'b1; entry_type_i = 2'b10; entry_addr_i = 24'h0F0F0F;
        entry_ch_i = 5'd9; entry_last_i = 1'b1;
        @(negedge clk);
        entry_valid_i = 1'b0;
        for (int c = 1; c < 20; c++) @(negedge clk);
        chk("pre_rst_busy", 20, {31'b0, busy_o}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 21, {31'b0, busy_o}, 32'd0);
        chk("mid_rst_cmd_valid", 21, {31'b0, cmd_valid_o}, 32'd0);
        chk("mid_rst_ch", 21, {27'b0, cmd_ch_o}, 32'd0);
        rst_n = 1'b1;
        chk("post_rst_ready", 21, {31'b0, entry_ready_o}, 32'd1);
        stray = 0;
        for (int c = 0; c < 80; c++) begin
            if (cmd_valid_o || entry_done_o || busy_o) stray++;
            @(negedge clk);
        end
        chk("post_rst_no_cmds", 0, stray, 0);

        // Short timing: T_MOD=1, T_RP=1, T_SPPR=3, T_HPPR=5.
        for (int h = 0; h < 2; h++) begin
            tact = (h == 1) ? 5 : 3;
            b_valid = 1'b1; b_type = (h == 1) ? 2'b10 : 2'b01;
            b_addr = 24'h00C0DE; b_ch = 5'd1; b_last = 1'b1;
            @(negedge clk);
            b_valid = 1'b0;
            at = '{-1, -1, -1, -1, -1, -1, -1, -1};
            done_at = -1;
            for (int k = 1; k <= 15; k++) begin
                if (b_cmd_valid && at[b_cmd] == -1) at[b_cmd] = k;
                if (b_entry_done && done_at == -1) done_at = k;
                @(negedge clk);
            end
            chk("fast_enter", h, at[1], 1);
            chk("fast_act", h, at[2], 2);
            chk("fast_pre", h, at[3], 2 + tact);
            chk("fast_exit", h, at[4], 3 + tact);
            chk("fast_done", h, done_at, 4 + tact);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
